dfi_init_sequencer: RTL and testbench

DFI_INIT_SEQUENCER -- requirements
Module: dfi_init_sequencer

---
 rtl/dfi_pkg.sv | 59 +++++
 rtl/dfi_wait_timer.sv | 38 +++
 rtl/dfi_init_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_dfi_init_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dfi_pkg.sv
// Shared types and encodings for the DFI power-up initialisation sequencer.
package dfi_pkg;

    // Sequencer states, in the order they are visited.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_HOLD = 3'd1,
        ST_CKE_WAIT = 3'd2,
        ST_MRS      = 3'd3,
        ST_MRS_WAIT = 3'd4,
        ST_ZQCL     = 3'd5,
        ST_ZQ_WAIT  = 3'd6,
        ST_DONE     = 3'd7
    } init_state_e;

    // Phase-0 command bits, active low.
    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } dfi_cmd_t;

    localparam dfi_cmd_t CMD_NOP  = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};
    localparam dfi_cmd_t CMD_MRS  = '{cs_n: 1'b0, ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b0};
    localparam dfi_cmd_t CMD_ZQCL = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b0};

    // Mode-register indices, driven on the bank lines during MRS.
    localparam int unsigned MR_IDX_W = 2;
    localparam logic [MR_IDX_W-1:0] MR0_IDX = 2'd0;
    localparam logic [MR_IDX_W-1:0] MR1_IDX = 2'd1;
    localparam logic [MR_IDX_W-1:0] MR2_IDX = 2'd2;
    localparam logic [MR_IDX_W-1:0] MR3_IDX = 2'd3;

    // ZQCL is identified by address bit 10 (long calibration).
    localparam int unsigned ZQCL_A10_BIT = 10;

    // Map MRS slot (0..3) to the register written: MR2, MR3, MR1, MR0.
    function automatic logic [MR_IDX_W-1:0] mr_seq_idx(input logic [MR_IDX_W-1:0] pos);
        logic [MR_IDX_W-1:0] idx;
        case (pos)
            2'd0:    idx = MR2_IDX;
            2'd1:    idx = MR3_IDX;
            2'd2:    idx = MR1_IDX;
            default: idx = MR0_IDX;
        endcase
        return idx;
    endfunction

    // Timer load for an N-cycle wait: N-1 (zero treated as one), clipped to the counter range.
    function automatic longint unsigned wait_load(input longint unsigned t, input int unsigned cnt_w);
        longint unsigned max_v;
        longint unsigned v;
        max_v = (64'd1 << cnt_w) - 64'd1;
        v     = (t == 64'd0) ? 64'd0 : t - 64'd1;
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/dfi_wait_timer.sv
// Loadable saturating down-counter shared by every wait state of the sequencer.
module dfi_wait_timer
    import dfi_pkg::*;
#(
    parameter int unsigned CNT_W = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load wins; otherwise count down and stick at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_c = (count_q == '0);

endmodule

// File: rtl/dfi_init_sequencer.sv
// DDR3 power-up sequencer: reset, CKE, MR2/MR3/MR1/MR0, ZQCL, then user command pass-through.
module dfi_init_sequencer
    import dfi_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 15,
    parameter int unsigned        BANK_W   = 3,
    parameter int unsigned        CNT_W    = 20,
    parameter int unsigned        T_RESET  = 100000,
    parameter int unsigned        T_CKE    = 250000,
    parameter int unsigned        T_MRD    = 12,
    parameter int unsigned        T_ZQINIT = 512,
    parameter logic [ADDR_W-1:0]  MR0      = '0,
    parameter logic [ADDR_W-1:0]  MR1      = '0,
    parameter logic [ADDR_W-1:0]  MR2      = '0,
    parameter logic [ADDR_W-1:0]  MR3      = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_start,
    output logic              init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [BANK_W-1:0] cmd_bank,
    input  logic              cmd_cs_n,
    input  logic              cmd_ras_n,
    input  logic              cmd_cas_n,
    input  logic              cmd_we_n,
    output logic [ADDR_W-1:0] dfi_address,
    output logic [BANK_W-1:0] dfi_bank,
    output logic              dfi_cs_n,
    output logic              dfi_ras_n,
    output logic              dfi_cas_n,
    output logic              dfi_we_n,
    output logic              dfi_cke,
    output logic              dfi_reset_n,
    output logic              dfi_odt
);

    localparam logic [CNT_W-1:0]  LD_RESET = CNT_W'(wait_load(64'(T_RESET), CNT_W));
    localparam logic [CNT_W-1:0]  LD_CKE   = CNT_W'(wait_load(64'(T_CKE), CNT_W));
    localparam logic [CNT_W-1:0]  LD_MRD   = CNT_W'(wait_load(64'(T_MRD), CNT_W));
    localparam logic [CNT_W-1:0]  LD_ZQ    = CNT_W'(wait_load(64'(T_ZQINIT), CNT_W));
    localparam logic [ADDR_W-1:0] ZQ_ADDR  = ADDR_W'(1) << ZQCL_A10_BIT;

    init_state_e         state_q;
    init_state_e         state_d;
    logic [MR_IDX_W-1:0] mr_pos_q;
    logic [MR_IDX_W-1:0] mr_pos_d;

    logic                timer_load_c;
    logic [CNT_W-1:0]    timer_value_c;
    logic                timer_expired_c;

    dfi_cmd_t            cmd_q;
    dfi_cmd_t            cmd_d;
    logic [ADDR_W-1:0]   address_q;
    logic [ADDR_W-1:0]   address_d;
    logic [BANK_W-1:0]   bank_q;
    logic [BANK_W-1:0]   bank_d;
    logic                cke_q;
    logic                cke_d;
    logic                reset_n_q;
    logic                reset_n_d;
    logic                init_done_q;
    logic                init_done_d;
    logic                cmd_ready_q;
    logic                cmd_ready_d;

    dfi_wait_timer #(
        .CNT_W (CNT_W)
    ) u_wait_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (timer_load_c),
        .value     (timer_value_c),
        .expired_c (timer_expired_c)
    );

    // State and MRS-slot registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            mr_pos_q <= '0;
        end else begin
            state_q  <= state_d;
            mr_pos_q <= mr_pos_d;
        end
    end

    // Next-state logic; each wait state leaves once the shared timer has run out.
    always_comb begin
        state_d  = state_q;
        mr_pos_d = mr_pos_q;
        case (state_q)
            ST_IDLE: begin
                mr_pos_d = '0;
                if (init_start) begin
                    state_d = ST_RST_HOLD;
                end
            end
            ST_RST_HOLD: begin
                if (timer_expired_c) begin
                    state_d = ST_CKE_WAIT;
                end
            end
            ST_CKE_WAIT: begin
                if (timer_expired_c) begin
                    state_d = ST_MRS;
                end
            end
            ST_MRS: begin
                state_d = ST_MRS_WAIT;
            end
            ST_MRS_WAIT: begin
                if (timer_expired_c) begin
                    if (mr_pos_q == 2'd3) begin
                        state_d = ST_ZQCL;
                    end else begin
                        mr_pos_d = mr_pos_q + 2'd1;
                        state_d  = ST_MRS;
                    end
                end
            end
            ST_ZQCL: begin
                state_d = ST_ZQ_WAIT;
            end
            ST_ZQ_WAIT: begin
                if (timer_expired_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so registered outputs line up with state_q.
    always_comb begin
        timer_load_c  = (state_d != state_q);
        timer_value_c = '0;
        cmd_d         = CMD_NOP;
        address_d     = '0;
        bank_d        = '0;
        reset_n_d     = !((state_d == ST_IDLE) || (state_d == ST_RST_HOLD));
        cke_d         = !((state_d == ST_IDLE) || (state_d == ST_RST_HOLD) ||
                          (state_d == ST_CKE_WAIT));
        init_done_d   = (state_d == ST_DONE);
        cmd_ready_d   = (state_d == ST_DONE);

        case (state_d)
            ST_RST_HOLD: timer_value_c = LD_RESET;
            ST_CKE_WAIT: timer_value_c = LD_CKE;
            ST_MRS_WAIT: timer_value_c = LD_MRD;
            ST_ZQ_WAIT:  timer_value_c = LD_ZQ;
            default:     timer_value_c = '0;
        endcase

        case (state_d)
            ST_MRS: begin
                cmd_d  = CMD_MRS;
                bank_d = BANK_W'(mr_seq_idx(mr_pos_d));
                case (mr_seq_idx(mr_pos_d))
                    MR0_IDX: address_d = MR0;
                    MR1_IDX: address_d = MR1;
                    MR2_IDX: address_d = MR2;
                    default: address_d = MR3;
                endcase
            end
            ST_ZQCL: begin
                cmd_d     = CMD_ZQCL;
                address_d = ZQ_ADDR;
            end
            ST_DONE: begin
                // A command is accepted only while cmd_ready is already high.
                if ((state_q == ST_DONE) && cmd_valid) begin
                    cmd_d     = '{cs_n: cmd_cs_n, ras_n: cmd_ras_n,
                                  cas_n: cmd_cas_n, we_n: cmd_we_n};
                    address_d = cmd_address;
                    bank_d    = cmd_bank;
                end
            end
            default: begin
                cmd_d = CMD_NOP;
            end
        endcase
    end

    // Output registers; reset forces the DRAM-safe idle pattern immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmd_q       <= CMD_NOP;
            address_q   <= '0;
            bank_q      <= '0;
            cke_q       <= 1'b0;
            reset_n_q   <= 1'b0;
            init_done_q <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            address_q   <= address_d;
            bank_q      <= bank_d;
            cke_q       <= cke_d;
            reset_n_q   <= reset_n_d;
            init_done_q <= init_done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign dfi_cs_n    = cmd_q.cs_n;
    assign dfi_ras_n   = cmd_q.ras_n;
    assign dfi_cas_n   = cmd_q.cas_n;
    assign dfi_we_n    = cmd_q.we_n;
    assign dfi_address = address_q;
    assign dfi_bank    = bank_q;
    assign dfi_cke     = cke_q;
    assign dfi_reset_n = reset_n_q;
    assign init_done   = init_done_q;
    assign cmd_ready   = cmd_ready_q;
    assign dfi_odt     = 1'b0;

endmodule

// File: tb/tb_dfi_init_sequencer.sv
// Scoreboard bench for dfi_init_sequencer: expected per-cycle outputs queued at stimulus time.
module tb_dfi_init_sequencer;

    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned BANK_W   = 3;
    localparam int unsigned CNT_W    = 20;
    localparam int unsigned T_RESET  = 8;
    localparam int unsigned T_CKE    = 4;
    localparam int unsigned T_MRD    = 4;
    localparam int unsigned T_ZQINIT = 16;
    localparam logic [14:0] MR0_V    = 15'h0520;
    localparam logic [14:0] MR1_V    = 15'h0044;
    localparam logic [14:0] MR2_V    = 15'h0008;
    localparam logic [14:0] MR3_V    = 15'h0000;

    localparam logic [2:0]  MRS_BANK [4] = '{3'd2, 3'd3, 3'd1, 3'd0};
    localparam logic [14:0] MRS_ADDR [4] = '{15'h0008, 15'h0000, 15'h0044, 15'h0520};

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_start = 1'b0;
    logic        init_done;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [14:0] cmd_address = '0;
    logic [2:0]  cmd_bank = '0;
    logic        cmd_cs_n = 1'b1;
    logic        cmd_ras_n = 1'b1;
    logic        cmd_cas_n = 1'b1;
    logic        cmd_we_n = 1'b1;
    logic [14:0] dfi_address;
    logic [2:0]  dfi_bank;
    logic        dfi_cs_n;
    logic        dfi_ras_n;
    logic        dfi_cas_n;
    logic        dfi_we_n;
    logic        dfi_cke;
    logic        dfi_reset_n;
    logic        dfi_odt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q [$];

    dfi_init_sequencer #(
        .ADDR_W   (ADDR_W),
        .BANK_W   (BANK_W),
        .CNT_W    (CNT_W),
        .T_RESET  (T_RESET),
        .T_CKE    (T_CKE),
        .T_MRD    (T_MRD),
        .T_ZQINIT (T_ZQINIT),
        .MR0      (MR0_V),
        .MR1      (MR1_V),
        .MR2      (MR2_V),
        .MR3      (MR3_V)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .init_start  (init_start),
        .init_done   (init_done),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_address (cmd_address),
        .cmd_bank    (cmd_bank),
        .cmd_cs_n    (cmd_cs_n),
        .cmd_ras_n   (cmd_ras_n),
        .cmd_cas_n   (cmd_cas_n),
        .cmd_we_n    (cmd_we_n),
        .dfi_address (dfi_address),
        .dfi_bank    (dfi_bank),
        .dfi_cs_n    (dfi_cs_n),
        .dfi_ras_n   (dfi_ras_n),
        .dfi_cas_n   (dfi_cas_n),
        .dfi_we_n    (dfi_we_n),
        .dfi_cke     (dfi_cke),
        .dfi_reset_n (dfi_reset_n),
        .dfi_odt     (dfi_odt)
    );

    always #5 sys_clk = ~sys_clk;

    // Pack {reset_n, cke, odt, done, ready, cs, ras, cas, we, bank, addr} into one word.
    function automatic logic [31:0] pack_vec(input logic rst_n, input logic cke, input logic odt,
                                             input logic done, input logic ready,
                                             input logic cs, input logic ras, input logic cas,
                                             input logic we, input logic [2:0] bank,
                                             input logic [14:0] addr);
        return {5'd0, rst_n, cke, odt, done, ready, cs, ras, cas, we, bank, addr};
    endfunction

    function automatic logic [31:0] nop_vec(input logic rst_n, input logic cke, input logic done);
        return pack_vec(rst_n, cke, 1'b0, done, done, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 15'd0);
    endfunction

    function automatic logic [31:0] obs_vec();
        return pack_vec(dfi_reset_n, dfi_cke, dfi_odt, init_done, cmd_ready,
                        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic randomize_cmd();
        cmd_address = 15'($urandom);
        cmd_bank    = 3'($urandom);
        cmd_cs_n    = 1'($urandom);
        cmd_ras_n   = 1'($urandom);
        cmd_cas_n   = 1'($urandom);
        cmd_we_n    = 1'($urandom);
    endtask

    // Expected cycle-by-cycle outputs for one full power-up sequence.
    task automatic push_init_seq();
        repeat (T_RESET) exp_q.push_back(nop_vec(1'b0, 1'b0, 1'b0));
        repeat (T_CKE)   exp_q.push_back(nop_vec(1'b1, 1'b0, 1'b0));
        for (int m = 0; m < 4; m++) begin
            exp_q.push_back(pack_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0, 1'b0, MRS_BANK[m], MRS_ADDR[m]));
            repeat (T_MRD) exp_q.push_back(nop_vec(1'b1, 1'b1, 1'b0));
        end
        exp_q.push_back(pack_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 15'h0400));
        repeat (T_ZQINIT) exp_q.push_back(nop_vec(1'b1, 1'b1, 1'b0));
        exp_q.push_back(nop_vec(1'b1, 1'b1, 1'b1));
    endtask

    // Start pulse, then compare each cycle; optionally pull reset at cycle abort_at.
    task automatic run_init(input int abort_at);
        int idx;
        idx = 0;
        @(negedge sys_clk);
        init_start = 1'b1;
        push_init_seq();
        while (exp_q.size() > 0) begin
            @(negedge sys_clk);
            check_eq($sformatf("init[%0d]", idx), obs_vec(), exp_q.pop_front());
            init_start = (idx == 8);
            cmd_valid  = (idx >= 12) && (idx < 40);
            randomize_cmd();
            if (idx == abort_at) begin
                #1;
                sys_rst_n = 1'b0;
                #1;
                check_eq("async_rst", obs_vec(), nop_vec(1'b0, 1'b0, 1'b0));
                exp_q.delete();
            end
            idx++;
        end
        init_start = 1'b0;
        cmd_valid  = 1'b0;
    endtask

    // User commands in DONE, pushed when driven and checked one cycle later.
    task automatic run_done();
        logic [31:0] e;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) begin
                cmd_valid   = 1'b1;
                cmd_address = 15'h1111;
                cmd_bank    = 3'd3;
                cmd_cs_n    = 1'b0;
                cmd_ras_n   = 1'b0;
                cmd_cas_n   = 1'b1;
                cmd_we_n    = 1'b1;
            end else if (k == 1) begin
                cmd_valid = 1'b0;
            end else begin
                cmd_valid = 1'($urandom);
                randomize_cmd();
            end
            init_start = (k == 3);
            if (cmd_valid) begin
                e = pack_vec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                             cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_bank, cmd_address);
            end else begin
                e = nop_vec(1'b1, 1'b1, 1'b1);
            end
            exp_q.push_back(e);
            @(negedge sys_clk);
            check_eq($sformatf("done[%0d]", k), obs_vec(), exp_q.pop_front());
        end
        cmd_valid  = 1'b0;
        init_start = 1'b0;
        repeat (2) begin
            @(negedge sys_clk);
            check_eq("done_idle", obs_vec(), nop_vec(1'b1, 1'b1, 1'b1));
        end
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge sys_clk);
        check_eq("in_reset", obs_vec(), nop_vec(1'b0, 1'b0, 1'b0));
        sys_rst_n = 1'b1;
        cmd_valid = 1'b1;
        randomize_cmd();
        repeat (3) begin
            @(negedge sys_clk);
            check_eq("idle_no_start", obs_vec(), nop_vec(1'b0, 1'b0, 1'b0));
        end
        cmd_valid = 1'b0;

        run_init(24);
        repeat (2) begin
            @(negedge sys_clk);
            check_eq("held_rst", obs_vec(), nop_vec(1'b0, 1'b0, 1'b0));
        end
        sys_rst_n = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            check_eq("idle_after_rst", obs_vec(), nop_vec(1'b0, 1'b0, 1'b0));
        end

        run_init(-1);
        run_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
